// File: rtl/mgpu_render_pkg.sv
// Shared render-path definitions.
// Holds the default coordinate width and the helpers that map an edge index
// to its vertex pair. Edges are enumerated lexicographically over pairs (a<b):
// (0,1),(0,2),...,(0,N-1),(1,2),...
package mgpu_render_pkg;

    localparam int COORD_W_DEF = 21;

    // Number of edges in the complete graph over n vertices.
    function automatic int num_edges(input int n);
        return n * (n - 1) / 2;
    endfunction

    // First (lower) vertex index of edge e.
    function automatic int edge_a(input int e, input int n);
        int k;
        int r;
        k = 0;
        r = 0;
        for (int a = 0; a < n; a++) begin
            for (int b = a + 1; b < n; b++) begin
                if (k == e) r = a;
                k++;
            end
        end
        return r;
    endfunction

    // Second (higher) vertex index of edge e.
    function automatic int edge_b(input int e, input int n);
        int k;
        int r;
        k = 0;
        r = 0;
        for (int a = 0; a < n; a++) begin
            for (int b = a + 1; b < n; b++) begin
                if (k == e) r = b;
                k++;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_hit_unit.sv
// Three-stage point-on-segment tester for one edge A->B.
//   S1: differences, |dx|, |dy|, bounding-box flags (box widened by THICK)
//   S2: cross product and thickness limit THICK*max(|dx|,|dy|)
//   S3: |cross| <= limit, ANDed with box flags and the stage-aligned enable
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ax_i..by_i        signed endpoint coordinates (sampled in S1)
//   px_i, py_i        signed pixel coordinates (sampled in S1)
//   en_s2_i           pixel enable/valid, already delayed to align with S2
//   hit_o             registered hit result (S3)
module edge_hit_unit
    import mgpu_render_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int THICK   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] ax_i,
    input  logic [COORD_W-1:0] ay_i,
    input  logic [COORD_W-1:0] bx_i,
    input  logic [COORD_W-1:0] by_i,
    input  logic [COORD_W-1:0] px_i,
    input  logic [COORD_W-1:0] py_i,
    input  logic               en_s2_i,
    output logic               hit_o
);

    localparam int DW = COORD_W + 1;      // coordinate differences
    localparam int BW = COORD_W + 2;      // box bounds with THICK margin
    localparam int PW = 2 * COORD_W + 2;  // products, exact

    localparam logic signed [BW-1:0] THICK_B = BW'(THICK);
    localparam logic        [PW-1:0] THICK_P = PW'(THICK);

    logic signed [COORD_W-1:0] ax, ay, bx, by, px, py;

    assign ax = $signed(ax_i);
    assign ay = $signed(ay_i);
    assign bx = $signed(bx_i);
    assign by = $signed(by_i);
    assign px = $signed(px_i);
    assign py = $signed(py_i);

    // ---------------- S1 ----------------
    logic signed [DW-1:0] dx_d, dy_d, pax_d, pay_d;
    logic signed [DW-1:0] dx_q, dy_q, pax_q, pay_q;
    logic        [DW-1:0] adx_d, ady_d, adx_q, ady_q;
    logic signed [BW-1:0] minx, maxx, miny, maxy;
    logic                 inx_d, iny_d, inx1_q, iny1_q;

    // NOTE: every always_comb output gets a value on every path (no else-less
    // if, no partial case), so no latch can be inferred.
    always_comb begin
        dx_d  = DW'(bx) - DW'(ax);
        dy_d  = DW'(by) - DW'(ay);
        pax_d = DW'(px) - DW'(ax);
        pay_d = DW'(py) - DW'(ay);
        adx_d = dx_d[DW-1] ? -dx_d : dx_d;
        ady_d = dy_d[DW-1] ? -dy_d : dy_d;
        minx  = (ax < bx) ? BW'(ax) : BW'(bx);
        maxx  = (ax < bx) ? BW'(bx) : BW'(ax);
        miny  = (ay < by) ? BW'(ay) : BW'(by);
        maxy  = (ay < by) ? BW'(by) : BW'(ay);
        inx_d = (BW'(px) >= minx - THICK_B) && (BW'(px) <= maxx + THICK_B);
        iny_d = (BW'(py) >= miny - THICK_B) && (BW'(py) <= maxy + THICK_B);
    end

    // ---------------- S2 ----------------
    logic signed [PW-1:0] cross_d, cross_q;
    logic        [DW-1:0] mag_d;
    logic        [PW-1:0] limit_d, limit_q;
    logic                 inx2_q, iny2_q;

    always_comb begin
        cross_d = PW'(pax_q) * PW'(dy_q) - PW'(pay_q) * PW'(dx_q);
        mag_d   = (adx_q >= ady_q) ? adx_q : ady_q;
        limit_d = THICK_P * PW'(mag_d);
    end

    // ---------------- S3 ----------------
    logic [PW-1:0] abs_cross;
    logic          hit_d, hit_q;

    always_comb begin
        abs_cross = cross_q[PW-1] ? -cross_q : cross_q;
        hit_d     = (abs_cross <= limit_q) && inx2_q && iny2_q && en_s2_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the pre-edge value of the stage before it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dx_q    <= '0;
            dy_q    <= '0;
            pax_q   <= '0;
            pay_q   <= '0;
            adx_q   <= '0;
            ady_q   <= '0;
            inx1_q  <= 1'b0;
            iny1_q  <= 1'b0;
            cross_q <= '0;
            limit_q <= '0;
            inx2_q  <= 1'b0;
            iny2_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            pax_q   <= pax_d;
            pay_q   <= pay_d;
            adx_q   <= adx_d;
            ady_q   <= ady_d;
            inx1_q  <= inx_d;
            iny1_q  <= iny_d;
            cross_q <= cross_d;
            limit_q <= limit_d;
            inx2_q  <= inx1_q;
            iny2_q  <= iny1_q;
            hit_q   <= hit_d;
        end
    end

    assign hit_o = hit_q;

endmodule

// File: rtl/edge_hit_pipe.sv
// Pipelined wireframe edge tester over the complete edge set of NUM_VTX
// vertices. Vertices are double-buffered (shadow written by vtx_load, copied
// to active on frame_start); each pixel is tested against every edge with a
// fixed 3-cycle latency and one pixel per cycle throughput.
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   vtx_load            write vtx_X/vtx_Y into shadow
//   vtx_X, vtx_Y        packed signed vertices, vertex i at [i*COORD_W +: COORD_W]
//   frame_start         copy shadow to active
//   edge_en             per-edge enable, sampled with the pixel
//   pix_valid           pixel qualifier
//   h_cnt_Q, v_cnt_Q    signed pixel coordinates
//   out_valid           result qualifier (pix_valid delayed 3 cycles)
//   on_line             per-edge hit bits, 0 for invalid pixels
//   any_hit             OR of on_line
module edge_hit_pipe
    import mgpu_render_pkg::*;
#(
    parameter  int NUM_VTX  = 4,
    parameter  int COORD_W  = COORD_W_DEF,
    parameter  int THICK    = 1,
    localparam int NUM_EDGE = num_edges(NUM_VTX)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       vtx_load,
    input  logic [NUM_VTX*COORD_W-1:0] vtx_X,
    input  logic [NUM_VTX*COORD_W-1:0] vtx_Y,
    input  logic                       frame_start,
    input  logic [NUM_EDGE-1:0]        edge_en,
    input  logic                       pix_valid,
    input  logic [COORD_W-1:0]         h_cnt_Q,
    input  logic [COORD_W-1:0]         v_cnt_Q,
    output logic                       out_valid,
    output logic [NUM_EDGE-1:0]        on_line,
    output logic                       any_hit
);

    logic [COORD_W-1:0] sh_x_q  [NUM_VTX];
    logic [COORD_W-1:0] sh_y_q  [NUM_VTX];
    logic [COORD_W-1:0] act_x_q [NUM_VTX];
    logic [COORD_W-1:0] act_y_q [NUM_VTX];

    // Same-cycle vtx_load + frame_start: active takes the pre-edge shadow while
    // shadow takes the new inputs, which falls out of edge-sampled registers.
    // NOTE: these are small flop arrays, not a RAM, so they are reset like any
    // other register and every vertex reads (0,0) after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VTX; i++) begin
                sh_x_q[i]  <= '0;
                sh_y_q[i]  <= '0;
                act_x_q[i] <= '0;
                act_y_q[i] <= '0;
            end
        end else begin
            if (vtx_load) begin
                for (int i = 0; i < NUM_VTX; i++) begin
                    sh_x_q[i] <= vtx_X[i*COORD_W +: COORD_W];
                    sh_y_q[i] <= vtx_Y[i*COORD_W +: COORD_W];
                end
            end
            if (frame_start) begin
                for (int i = 0; i < NUM_VTX; i++) begin
                    act_x_q[i] <= sh_x_q[i];
                    act_y_q[i] <= sh_y_q[i];
                end
            end
        end
    end

    // Valid and enable travel alongside the per-edge units. The enable is
    // folded with pix_valid at entry so invalid pixels always report 0.
    logic [2:0]          vld_q;
    logic [NUM_EDGE-1:0] en_s1_d, en_s1_q, en_s2_q;

    always_comb begin
        en_s1_d = pix_valid ? edge_en : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            en_s1_q <= '0;
            en_s2_q <= '0;
        end else begin
            vld_q   <= {vld_q[1:0], pix_valid};
            en_s1_q <= en_s1_d;
            en_s2_q <= en_s1_q;
        end
    end

    for (genvar e = 0; e < NUM_EDGE; e++) begin : g_edge
        localparam int A = edge_a(e, NUM_VTX);
        localparam int B = edge_b(e, NUM_VTX);

        edge_hit_unit #(
            .COORD_W (COORD_W),
            .THICK   (THICK)
        ) u_unit (
            .clk     (clk),
            .rst_n   (rst_n),
            .ax_i    (act_x_q[A]),
            .ay_i    (act_y_q[A]),
            .bx_i    (act_x_q[B]),
            .by_i    (act_y_q[B]),
            .px_i    (h_cnt_Q),
            .py_i    (v_cnt_Q),
            .en_s2_i (en_s2_q[e]),
            .hit_o   (on_line[e])
        );
    end

    assign out_valid = vld_q[2];
    assign any_hit   = |on_line;

endmodule

// File: tb/tb_edge_hit_pipe.sv
// Directed bench for edge_hit_pipe (NUM_VTX=4, COORD_W=21, THICK=1).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_edge_hit_pipe;

    localparam int NV = 4;
    localparam int CW = 21;
    localparam int TH = 1;
    localparam int NE = 6;
    localparam longint M = (64'sd1 <<< 20) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            vtx_load = 1'b0;
    logic [NV*CW-1:0] vtx_X = '0;
    logic [NV*CW-1:0] vtx_Y = '0;
    logic            frame_start = 1'b0;
    logic [NE-1:0]   edge_en = '1;
    logic            pix_valid = 1'b0;
    logic [CW-1:0]   h_cnt_Q = '0;
    logic [CW-1:0]   v_cnt_Q = '0;
    logic            out_valid;
    logic [NE-1:0]   on_line;
    logic            any_hit;

    int errors = 0;
    int checks = 0;

    // Bench-side copy of the vertex buffers.
    longint sh_x [NV];
    longint sh_y [NV];
    longint act_x [NV];
    longint act_y [NV];
    int ea [NE] = '{0, 0, 0, 1, 1, 2};
    int eb [NE] = '{1, 2, 3, 2, 3, 3};

    edge_hit_pipe #(
        .NUM_VTX (NV),
        .COORD_W (CW),
        .THICK   (TH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vtx_load    (vtx_load),
        .vtx_X       (vtx_X),
        .vtx_Y       (vtx_Y),
        .frame_start (frame_start),
        .edge_en     (edge_en),
        .pix_valid   (pix_valid),
        .h_cnt_Q     (h_cnt_Q),
        .v_cnt_Q     (v_cnt_Q),
        .out_valid   (out_valid),
        .on_line     (on_line),
        .any_hit     (any_hit)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    // Reference hit vector from the geometric definition, 64-bit arithmetic.
    function automatic logic [NE-1:0] ref_hit(input longint px, input longint py,
                                              input logic [NE-1:0] en);
        logic [NE-1:0] r;
        longint ax, ay, bx, by, dx, dy, cr, adx, ady, lim;
        r = '0;
        for (int e = 0; e < NE; e++) begin
            ax  = act_x[ea[e]];
            ay  = act_y[ea[e]];
            bx  = act_x[eb[e]];
            by  = act_y[eb[e]];
            dx  = bx - ax;
            dy  = by - ay;
            cr  = (px - ax) * dy - (py - ay) * dx;
            if (cr < 0) cr = -cr;
            adx = (dx < 0) ? -dx : dx;
            ady = (dy < 0) ? -dy : dy;
            lim = TH * ((adx > ady) ? adx : ady);
            r[e] = en[e] && (cr <= lim)
                && (px >= ((ax < bx) ? ax : bx) - TH) && (px <= ((ax < bx) ? bx : ax) + TH)
                && (py >= ((ay < by) ? ay : by) - TH) && (py <= ((ay < by) ? by : ay) + TH);
        end
        return r;
    endfunction

    task automatic load_vtx(input longint x0, input longint y0, input longint x1, input longint y1,
                            input longint x2, input longint y2, input longint x3, input longint y3,
                            input logic fs);
        @(negedge clk);
        vtx_load    = 1'b1;
        frame_start = fs;
        vtx_X = {CW'(x3), CW'(x2), CW'(x1), CW'(x0)};
        vtx_Y = {CW'(y3), CW'(y2), CW'(y1), CW'(y0)};
        if (fs) begin
            act_x = sh_x;
            act_y = sh_y;
        end
        sh_x = '{x0, x1, x2, x3};
        sh_y = '{y0, y1, y2, y3};
        @(negedge clk);
        vtx_load    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic load_square(input longint ox, input longint oy, input logic fs);
        load_vtx(ox, oy, ox + 40, oy, ox, oy + 40, ox + 40, oy + 40, fs);
    endtask

    task automatic commit();
        @(negedge clk);
        frame_start = 1'b1;
        act_x = sh_x;
        act_y = sh_y;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Send one pixel; report out_valid one cycle early and the full result.
    task automatic probe(input longint px, input longint py, input logic [NE-1:0] en,
                         output logic early_v, output logic v,
                         output logic [NE-1:0] on, output logic any);
        @(negedge clk);
        h_cnt_Q   = CW'(px);
        v_cnt_Q   = CW'(py);
        edge_en   = en;
        pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
        early_v = out_valid;
        @(negedge clk);
        v   = out_valid;
        on  = on_line;
        any = any_hit;
    endtask

    task automatic test_reset();
        logic ev, v, an;
        logic [NE-1:0] on;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, on_line, any_hit} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b on=%b any=%b, want all 0", out_valid, on_line, any_hit);
        end
        for (int i = 0; i < NV; i++) begin
            sh_x[i] = 0; sh_y[i] = 0; act_x[i] = 0; act_y[i] = 0;
        end
        rst_n = 1'b1;
        // All vertices at (0,0): every edge is the 3x3 square around the origin.
        probe(1, -1, 6'h3F, ev, v, on, an);
        checks++;
        if (ev !== 1'b0 || v !== 1'b1 || on !== 6'b111111 || an !== 1'b1) begin
            errors++;
            $display("FAIL reset_zero_vtx_hit: got early=%b v=%b on=%b any=%b, want 0 1 111111 1", ev, v, on, an);
        end
        probe(2, 0, 6'h3F, ev, v, on, an);
        checks++;
        if (v !== 1'b1 || on !== 6'b000000 || an !== 1'b0) begin
            errors++;
            $display("FAIL reset_zero_vtx_miss: got v=%b on=%b any=%b, want 1 000000 0", v, on, an);
        end
    endtask

    task automatic test_basic();
        longint px [3] = '{30, 30, 30};
        longint py [3] = '{10, 30, 12};
        logic [NE-1:0] want [3] = '{6'b000001, 6'b001100, 6'b000000};
        logic ev, v, an;
        logic [NE-1:0] on;
        load_square(10, 10, 1'b0);
        commit();
        for (int i = 0; i < 3; i++) begin
            probe(px[i], py[i], 6'h3F, ev, v, on, an);
            checks++;
            if (ev !== 1'b0 || v !== 1'b1 || on !== want[i] || an !== (want[i] != 0)) begin
                errors++;
                $display("FAIL basic_pix%0d (%0d,%0d): got early=%b v=%b on=%b any=%b, want 0 1 %b %b",
                         i, px[i], py[i], ev, v, on, an, want[i], want[i] != 0);
            end
        end
    endtask

    task automatic test_double_buffer();
        logic ev, v, an;
        logic [NE-1:0] on, r1, r2;
        // Shadow only: results must still use the first square.
        load_square(110, 10, 1'b0);
        probe(30, 10, 6'h3F, ev, v, on, an);
        checks++;
        if (v !== 1'b1 || on !== 6'b000001) begin
            errors++;
            $display("FAIL dbuf_shadow_only: got v=%b on=%b, want 1 000001", v, on);
        end
        // Pixel in the frame_start cycle uses old set; next pixel uses new set.
        @(negedge clk);
        frame_start = 1'b1;
        h_cnt_Q = CW'(30); v_cnt_Q = CW'(10); edge_en = 6'h3F; pix_valid = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        act_x = sh_x; act_y = sh_y;
        h_cnt_Q = CW'(130); v_cnt_Q = CW'(10);
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
        r1 = on_line;
        @(negedge clk);
        r2 = on_line;
        checks++;
        if (r1 !== 6'b000001) begin
            errors++;
            $display("FAIL dbuf_old_in_fs_cycle: got on=%b, want 000001", r1);
        end
        checks++;
        if (r2 !== 6'b000001) begin
            errors++;
            $display("FAIL dbuf_new_after_fs: got on=%b, want 000001", r2);
        end
        // Simultaneous load + commit: active gets the previous shadow.
        load_square(210, 10, 1'b0);
        load_square(310, 10, 1'b1);
        probe(230, 10, 6'h3F, ev, v, on, an);
        checks++;
        if (on !== 6'b000001) begin
            errors++;
            $display("FAIL dbuf_sim_old_shadow: got on=%b, want 000001", on);
        end
        probe(330, 10, 6'h3F, ev, v, on, an);
        checks++;
        if (on !== 6'b000000) begin
            errors++;
            $display("FAIL dbuf_sim_not_new: got on=%b, want 000000", on);
        end
        commit();
        probe(330, 10, 6'h3F, ev, v, on, an);
        checks++;
        if (on !== 6'b000001) begin
            errors++;
            $display("FAIL dbuf_second_commit: got on=%b, want 000001", on);
        end
    endtask

    task automatic test_degenerate();
        logic ev, v, an;
        logic [NE-1:0] on;
        load_vtx(100, 100, 100, 100, 500, 500, 900, 100, 1'b0);
        commit();
        probe(101, 99, 6'h3F, ev, v, on, an);
        checks++;
        if (v !== 1'b1 || on[0] !== 1'b1) begin
            errors++;
            $display("FAIL degen_inside: got v=%b e0=%b, want 1 1", v, on[0]);
        end
        probe(102, 100, 6'h3F, ev, v, on, an);
        checks++;
        if (v !== 1'b1 || on[0] !== 1'b0) begin
            errors++;
            $display("FAIL degen_outside: got v=%b e0=%b, want 1 0", v, on[0]);
        end
    endtask

    task automatic test_edge_en();
        logic ev, v, an;
        logic [NE-1:0] on;
        load_square(10, 10, 1'b0);
        commit();
        probe(30, 10, 6'b111110, ev, v, on, an);
        checks++;
        if (v !== 1'b1 || on !== 6'b000000 || an !== 1'b0) begin
            errors++;
            $display("FAIL edge_en_mask: got v=%b on=%b any=%b, want 1 000000 0", v, on, an);
        end
    endtask

    task automatic test_extremes();
        logic ev, v, an;
        logic [NE-1:0] on;
        load_vtx(-M, -M, M, -M, -M, M, M, M, 1'b0);
        commit();
        probe(0, 0, 6'h3F, ev, v, on, an);
        checks++;
        if (v !== 1'b1 || on !== 6'b001100 || an !== 1'b1) begin
            errors++;
            $display("FAIL extreme_mid: got v=%b on=%b any=%b, want 1 001100 1", v, on, an);
        end
        probe(M, M - 2, 6'h3F, ev, v, on, an);
        checks++;
        if (v !== 1'b1 || on !== 6'b010000) begin
            errors++;
            $display("FAIL extreme_corner: got v=%b on=%b, want 1 010000", v, on);
        end
    endtask

    task automatic test_back_to_back();
        logic [NE-1:0] exp_on [100];
        logic          exp_v  [100];
        longint px, py;
        logic [NE-1:0] en;
        logic vv;
        load_square(10, 10, 1'b0);
        commit();
        for (int i = 0; i < 103; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                checks++;
                if (out_valid !== exp_v[i-3] || on_line !== exp_on[i-3] || any_hit !== (exp_on[i-3] != 0)) begin
                    errors++;
                    $display("FAIL stream_pix%0d: got v=%b on=%b any=%b, want %b %b %b",
                             i - 3, out_valid, on_line, any_hit, exp_v[i-3], exp_on[i-3], exp_on[i-3] != 0);
                end
            end
            if (i < 100) begin
                px = longint'($urandom_range(5, 55));
                case ($urandom_range(0, 3))
                    0:       py = longint'($urandom_range(5, 55));
                    1:       py = 10;
                    2:       py = px;
                    default: py = 60 - px;
                endcase
                en = ($urandom_range(0, 3) == 0) ? NE'($urandom) : 6'h3F;
                vv = ($urandom_range(0, 7) != 0);
                h_cnt_Q   = CW'(px);
                v_cnt_Q   = CW'(py);
                edge_en   = en;
                pix_valid = vv;
                exp_v[i]  = vv;
                exp_on[i] = vv ? ref_hit(px, py, en) : '0;
            end else begin
                pix_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        h_cnt_Q = CW'(30); v_cnt_Q = CW'(10); edge_en = 6'h3F; pix_valid = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || on_line !== 6'b000001) begin
            errors++;
            $display("FAIL midrst_prefill: got v=%b on=%b, want 1 000001", out_valid, on_line);
        end
        #2;
        rst_n = 1'b0;
        h_cnt_Q = CW'(1); v_cnt_Q = CW'(-1);
        #1;
        checks++;
        if ({out_valid, on_line, any_hit} !== '0) begin
            errors++;
            $display("FAIL midrst_async_clear: got v=%b on=%b any=%b, want all 0", out_valid, on_line, any_hit);
        end
        for (int i = 0; i < NV; i++) begin
            sh_x[i] = 0; sh_y[i] = 0; act_x[i] = 0; act_y[i] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_refill_c1: got v=%b, want 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_refill_c2: got v=%b, want 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || on_line !== 6'b111111 || any_hit !== 1'b1) begin
            errors++;
            $display("FAIL midrst_refill_c3: got v=%b on=%b any=%b, want 1 111111 1", out_valid, on_line, any_hit);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_double_buffer();
        test_degenerate();
        test_edge_en();
        test_extremes();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
